// File: rtl/eager_pkg.sv
// eager_pkg: shared state encoding and default widths for the eager dual-path controller
package eager_pkg;
  localparam int PC_W_DEF = 10;
  typedef enum logic [1:0] {
    DUAL     = 2'd0,
    REFILL_T = 2'd1,
    REFILL_N = 2'd2,
    SINGLE   = 2'd3
  } state_e;
endpackage

// File: rtl/eager_path_ctrl_if.sv
// eager_path_ctrl_if: branch resolution inputs and redirect/status outputs of both fetch paths
interface eager_path_ctrl_if
  import eager_pkg::*;
#(
  parameter int PC_W         = PC_W_DEF,
  parameter int SLOTS        = 2,
  parameter int FLUSH_STAGES = 2,
  parameter int CNT_W        = 16
);
  logic                    dual_en;
  logic [SLOTS-1:0]        ex_br_t, ex_br_n, ex_taken_t, ex_taken_n, id_br_t, id_br_n;
  logic [PC_W-1:0]         ex_nextpc_t, ex_nextpc_n, id_nextpc_t, id_nextpc_n;
  logic [SLOTS*PC_W-1:0]   id_bta_n;
  logic                    correct_en_t, correct_en_n;
  logic [PC_W-1:0]         correction_t, correction_n;
  logic [FLUSH_STAGES-1:0] flush_t, flush_n;
  logic                    path_valid_t, path_valid_n;
  logic [1:0]              state;
  logic [CNT_W-1:0]        resolve_cnt, taken_cnt;
  modport master (
    output dual_en, ex_br_t, ex_br_n, ex_taken_t, ex_taken_n, id_br_t, id_br_n,
           ex_nextpc_t, ex_nextpc_n, id_nextpc_t, id_nextpc_n, id_bta_n,
    input  correct_en_t, correct_en_n, correction_t, correction_n, flush_t, flush_n,
           path_valid_t, path_valid_n, state, resolve_cnt, taken_cnt
  );
  modport slave (
    input  dual_en, ex_br_t, ex_br_n, ex_taken_t, ex_taken_n, id_br_t, id_br_n,
           ex_nextpc_t, ex_nextpc_n, id_nextpc_t, id_nextpc_n, id_bta_n,
    output correct_en_t, correct_en_n, correction_t, correction_n, flush_t, flush_n,
           path_valid_t, path_valid_n, state, resolve_cnt, taken_cnt
  );
endinterface

// File: rtl/eager_path_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/eager_path_ctrl.sv
// eager_path_ctrl: resolves EX branches across the taken/not-taken paths, redirects the loser
// and holds it invalid through a refill window
module eager_path_ctrl
  import eager_pkg::*;
#(
  parameter int PC_W         = PC_W_DEF,
  parameter int SLOTS        = 2,
  parameter int FLUSH_STAGES = 2,
  parameter int RECOVER_CYC  = 2,
  parameter int CNT_W        = 16
) (
  input logic              clk,
  input logic              rst,
  eager_path_ctrl_if.slave bus
);
  localparam int RW = $clog2(RECOVER_CYC + 1);
  localparam logic [RW-1:0] RELOAD = RW'(RECOVER_CYC);
  state_e          state_q, state_d;
  logic [RW-1:0]   cnt_q, cnt_d;
  logic            pv_t_q, pv_n_q, pv_t_d, pv_n_d;
  logic            use_t, use_n, resolve, taken, bib, redir_t, redir_n;
  logic [PC_W-1:0] bta_sel;
  function automatic logic [PC_W-1:0] lowest_bta(input logic [SLOTS-1:0] br,
                                                 input logic [SLOTS*PC_W-1:0] bta);
    lowest_bta = bta[PC_W-1:0];
    for (int i = SLOTS - 1; i >= 0; i--) if (br[i]) lowest_bta = bta[i*PC_W +: PC_W];
  endfunction
  // only branches on a path that may still commit count as a resolution
  always_comb begin
    use_t   = state_q == DUAL || state_q == REFILL_N;
    use_n   = state_q == DUAL || state_q == REFILL_T;
    resolve = (use_t & (|bus.ex_br_t)) | (use_n & (|bus.ex_br_n));
    taken   = (use_t & (|(bus.ex_br_t & bus.ex_taken_t))) | (use_n & (|(bus.ex_br_n & bus.ex_taken_n)));
    bib     = ((|bus.id_br_t) | (|bus.id_br_n)) & (bus.id_nextpc_t != bus.id_nextpc_n);
    bta_sel = lowest_bta(bus.id_br_n, bus.id_bta_n);
    redir_n = !rst && (state_q == SINGLE ? bus.dual_en : resolve && taken);
    redir_t = !rst && resolve && !taken;
  end
  always_comb begin
    bus.correct_en_t = redir_t;
    bus.correct_en_n = redir_n;
    bus.flush_t      = {FLUSH_STAGES{redir_t}};
    bus.flush_n      = {FLUSH_STAGES{redir_n}};
    bus.correction_t = !redir_t ? '0 : bib ? bta_sel : bus.ex_nextpc_n;
    bus.correction_n = !redir_n ? '0 : (bib && state_q != SINGLE) ? bus.id_nextpc_t : bus.ex_nextpc_t;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.dual_en) begin
      state_d = SINGLE;
      cnt_d   = '0;
    end else if (state_q == SINGLE) begin
      state_d = REFILL_N;
      cnt_d   = RELOAD;
    end else if (resolve) begin
      state_d = taken ? REFILL_N : REFILL_T;
      cnt_d   = RELOAD;
    end else if (state_q != DUAL) begin
      state_d = (cnt_q == RW'(1)) ? DUAL : state_q;
      cnt_d   = cnt_q - 1'b1;
    end
    pv_t_d = state_d != REFILL_T;
    pv_n_d = state_d == DUAL || state_d == REFILL_T;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DUAL;
      cnt_q   <= '0;
      pv_t_q  <= 1'b1;
      pv_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pv_t_q  <= pv_t_d;
      pv_n_q  <= pv_n_d;
    end
  end
  assign bus.state        = state_q;
  assign bus.path_valid_t = pv_t_q;
  assign bus.path_valid_n = pv_n_q;
  sat_counter #(.CNT_W(CNT_W)) u_resolve_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(resolve),
    .cnt_o(bus.resolve_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(resolve & taken),
    .cnt_o(bus.taken_cnt)
  );
endmodule

// File: tb/tb_eager_path_ctrl.sv
// tb_eager_path_ctrl: directed vector table plus refill, single-path and saturation sequences
module tb_eager_path_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eager_path_ctrl_if #(.PC_W(10), .SLOTS(2), .FLUSH_STAGES(2), .CNT_W(16)) bus ();
  eager_path_ctrl_if #(.PC_W(10), .SLOTS(2), .FLUSH_STAGES(2), .CNT_W(2)) sbus ();

  assign sbus.dual_en     = bus.dual_en;
  assign sbus.ex_br_t     = bus.ex_br_t;
  assign sbus.ex_br_n     = bus.ex_br_n;
  assign sbus.ex_taken_t  = bus.ex_taken_t;
  assign sbus.ex_taken_n  = bus.ex_taken_n;
  assign sbus.id_br_t     = bus.id_br_t;
  assign sbus.id_br_n     = bus.id_br_n;
  assign sbus.ex_nextpc_t = bus.ex_nextpc_t;
  assign sbus.ex_nextpc_n = bus.ex_nextpc_n;
  assign sbus.id_nextpc_t = bus.id_nextpc_t;
  assign sbus.id_nextpc_n = bus.id_nextpc_n;
  assign sbus.id_bta_n    = bus.id_bta_n;

  eager_path_ctrl #(.PC_W(10), .SLOTS(2), .FLUSH_STAGES(2), .RECOVER_CYC(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  eager_path_ctrl #(.PC_W(10), .SLOTS(2), .FLUSH_STAGES(2), .RECOVER_CYC(2), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .bus(sbus)
  );

  typedef struct {
    string       name;
    logic        de;
    logic [1:0]  bt, bn, tt, tn, ibt, ibn;
    logic [9:0]  ent, enn, ipt, ipn;
    logic [19:0] bta;
    logic [25:0] exp_o;
    logic [3:0]  exp_s;
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t v[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.correct_en_t, bus.correct_en_n, bus.correction_t, bus.correction_n,
                bus.flush_t, bus.flush_n});
  endfunction

  function automatic logic [31:0] st();
    return 32'({bus.state, bus.path_valid_t, bus.path_valid_n});
  endfunction

  task automatic clear();
    bus.dual_en = 1'b1;
    bus.ex_br_t = '0; bus.ex_br_n = '0; bus.ex_taken_t = '0; bus.ex_taken_n = '0;
    bus.id_br_t = '0; bus.id_br_n = '0;
    bus.ex_nextpc_t = '0; bus.ex_nextpc_n = '0; bus.id_nextpc_t = '0; bus.id_nextpc_n = '0;
    bus.id_bta_n = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear();
    tick();
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t x);
    bus.dual_en = x.de;
    bus.ex_br_t = x.bt; bus.ex_br_n = x.bn; bus.ex_taken_t = x.tt; bus.ex_taken_n = x.tn;
    bus.id_br_t = x.ibt; bus.id_br_n = x.ibn;
    bus.ex_nextpc_t = x.ent; bus.ex_nextpc_n = x.enn;
    bus.id_nextpc_t = x.ipt; bus.id_nextpc_n = x.ipn;
    bus.id_bta_n = x.bta;
  endtask

  initial begin
    // {cen_t, cen_n, corr_t, corr_n, flush_t, flush_n} and {state, pv_t, pv_n} after the edge
    v[0] = '{"taken_t_noid", 1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 10'h40, 10'h99, 10'h12, 10'h13,
             {10'h7F, 10'h55}, {1'b0, 1'b1, 10'h000, 10'h040, 2'b00, 2'b11}, 4'b1010};
    v[1] = '{"nt_bib_slot1", 1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 10'h40, 10'h99, 10'h12, 10'h13,
             {10'h7F, 10'h55}, {1'b1, 1'b0, 10'h07F, 10'h000, 2'b11, 2'b00}, 4'b0101};
    v[2] = '{"nt_same_idpc", 1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 10'h40, 10'h99, 10'h12, 10'h12,
             {10'h7F, 10'h55}, {1'b1, 1'b0, 10'h099, 10'h000, 2'b11, 2'b00}, 4'b0101};
    v[3] = '{"nt_bib_lowest", 1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 10'h40, 10'h99, 10'h12, 10'h13,
             {10'h7F, 10'h55}, {1'b1, 1'b0, 10'h055, 10'h000, 2'b11, 2'b00}, 4'b0101};
    v[4] = '{"nt_bib_idt_only", 1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 10'h40, 10'h99, 10'h12, 10'h13,
             {10'h7F, 10'h55}, {1'b1, 1'b0, 10'h055, 10'h000, 2'b11, 2'b00}, 4'b0101};
    v[5] = '{"taken_n_bib", 1, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 10'h40, 10'h99, 10'h12, 10'h13,
             {10'h7F, 10'h55}, {1'b0, 1'b1, 10'h000, 10'h012, 2'b00, 2'b11}, 4'b1010};
    v[6] = '{"no_branch", 1, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 10'h40, 10'h99, 10'h12, 10'h13,
             {10'h7F, 10'h55}, 26'h0, 4'b0011};
    v[7] = '{"taken_other_slot", 1, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 10'h40, 10'h99, 10'h12, 10'h13,
             {10'h7F, 10'h55}, {1'b1, 1'b0, 10'h099, 10'h000, 2'b11, 2'b00}, 4'b0101};
    v[8] = '{"resolve_then_single", 0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 10'h40, 10'h99, 10'h12, 10'h13,
             {10'h7F, 10'h55}, {1'b0, 1'b1, 10'h000, 10'h040, 2'b00, 2'b11}, 4'b1110};
    v[9] = '{"both_paths_taken_n", 1, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 10'h40, 10'h99, 10'h12, 10'h13,
             {10'h7F, 10'h55}, {1'b0, 1'b1, 10'h000, 10'h040, 2'b00, 2'b11}, 4'b1010};

    rst = 1'b1;
    clear();
    bus.ex_br_t = 2'b01; bus.ex_taken_t = 2'b01; bus.ex_nextpc_t = 10'h40;
    tick();
    tick();
    chk("rst_outs_quiet", outs(), 32'h0);
    chk("rst_state", st(), 32'h3);
    chk("rst_resolve_cnt", 32'(bus.resolve_cnt), 32'h0);
    chk("rst_taken_cnt", 32'(bus.taken_cnt), 32'h0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      apply(v[i]);
      #1;
      chk({v[i].name, "_outs"}, outs(), 32'(v[i].exp_o));
      tick();
      chk({v[i].name, "_state"}, st(), 32'(v[i].exp_s));
    end

    do_reset();
    apply(v[0]);
    tick();
    chk("refill_n_entry", st(), 32'hA);
    clear();
    tick();
    chk("refill_n_hold", st(), 32'hA);
    tick();
    chk("refill_n_exit", st(), 32'h3);

    do_reset();
    apply(v[0]);
    tick();
    clear();
    bus.ex_br_n = 2'b01; bus.ex_taken_n = 2'b01; bus.ex_nextpc_t = 10'h44;
    #1;
    chk("refill_n_ignore_n", outs(), 32'h0);
    tick();
    chk("refill_n_after_ignore", st(), 32'hA);
    clear();
    bus.ex_br_t = 2'b01; bus.ex_nextpc_n = 10'h33;
    #1;
    chk("refill_n_redirect_t", outs(), 32'({1'b1, 1'b0, 10'h033, 10'h000, 2'b11, 2'b00}));
    tick();
    chk("rerefill_t_entry", st(), 32'h5);
    clear();
    tick();
    chk("rerefill_t_reload", st(), 32'h5);
    tick();
    chk("rerefill_t_exit", st(), 32'h3);

    do_reset();
    bus.dual_en = 1'b0;
    tick();
    chk("single_entry", st(), 32'hE);
    bus.ex_br_t = 2'b01; bus.ex_taken_t = 2'b01; bus.ex_br_n = 2'b01; bus.ex_nextpc_t = 10'h40;
    #1;
    chk("single_ignore_br", outs(), 32'h0);
    tick();
    chk("single_hold", st(), 32'hE);
    chk("single_no_count", 32'(bus.resolve_cnt), 32'h0);
    clear();
    bus.ex_nextpc_t = 10'h20;
    #1;
    chk("single_exit_redirect", outs(), 32'({1'b0, 1'b1, 10'h000, 10'h020, 2'b00, 2'b11}));
    tick();
    chk("single_exit_state", st(), 32'hA);

    do_reset();
    bus.ex_br_t = 2'b01; bus.ex_taken_t = 2'b01; bus.ex_nextpc_t = 10'h40;
    repeat (5) tick();
    chk("sat2_resolve", 32'(sbus.resolve_cnt), 32'd3);
    chk("sat2_taken", 32'(sbus.taken_cnt), 32'd3);
    chk("cnt16_resolve", 32'(bus.resolve_cnt), 32'd5);
    chk("cnt16_taken", 32'(bus.taken_cnt), 32'd5);
    bus.ex_taken_t = 2'b00;
    tick();
    chk("sat2_resolve_held", 32'(sbus.resolve_cnt), 32'd3);
    chk("cnt16_resolve_nt", 32'(bus.resolve_cnt), 32'd6);
    chk("cnt16_taken_nt", 32'(bus.taken_cnt), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/eager_path_ctrl.md
Name: eager_path_ctrl

Overview:
- Parametrised successor to the dual-path branch correction logic for the eager-execution dual-issue core.
- Both fetch paths run concurrently: path T assumes taken, path N assumes not-taken.
- On EX-stage branch resolution the block redirects and flushes the losing path, then tracks that path through a refill window.
- Adds a single-path mode, a configurable issue width, a configurable flush depth and resolution statistics.

Parameters:
PC_W, 10, PC / address width
SLOTS, 2, issue slots per path (branch signals per slot)
FLUSH_STAGES, 2, front-end stages flushed on redirect (bit 0 = IF/ID, bit 1 = ID/EX, ...)
RECOVER_CYC, 2, cycles a redirected path stays invalid after redirect (>=1)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
dual_en  in  1  1 = dual-path mode, 0 = single-path (T only)
ex_br_t, ex_br_n  in  SLOTS  branch present in EX, per slot, per path
ex_taken_t, ex_taken_n  in  SLOTS  resolved taken, per slot
id_br_t, id_br_n  in  SLOTS  branch present in ID, per slot
ex_nextpc_t, ex_nextpc_n  in  PC_W  next PC from EX of each path
id_nextpc_t, id_nextpc_n  in  PC_W  next PC from ID of each path
id_bta_n  in  SLOTS*PC_W  ID-stage branch targets of path N, slot 0 in LSBs
correct_en_t, correct_en_n  out  1  redirect strobe per path
correction_t, correction_n  out  PC_W  redirect PC
flush_t, flush_n  out  FLUSH_STAGES  flush per stage per path
path_valid_t, path_valid_n  out  1  path results may commit
state  out  2  FSM state (DUAL=0, REFILL_T=1, REFILL_N=2, SINGLE=3)
resolve_cnt, taken_cnt  out  CNT_W  saturating statistics counters

Behaviour:
- Reset (sync, dominates everything): state=DUAL, refill counter=0, counters=0, path_valid_t=path_valid_n=1. Redirect outputs are 0 whenever rst=1.
- Redirect outputs are combinational from current state and inputs (same-cycle redirect). State, refill counter and counters update on the clk edge.
- Definitions, for each path p:
  - br_p = |ex_br_p
  - tk_p = |(ex_br_p & ex_taken_p)
  - resolve = br_t | br_n in DUAL; br_t only in REFILL_N; br_n only in REFILL_T; never in SINGLE.
  - taken = tk_t | tk_n, restricted to the same paths as resolve.
- Target selection when resolve=1:
  - bib = (|id_br_t | |id_br_n) & (id_nextpc_t != id_nextpc_n).
  - taken: redirect N. correction_n = bib ? id_nextpc_t : ex_nextpc_t.
  - not taken: redirect T. correction_t = bib ? id_bta_n[lowest slot with id_br_n set] : ex_nextpc_n. If no id_br_n bit is set, use slot 0.
  - The redirected path gets correct_en=1 and flush all-ones. The other path's outputs are all 0; its correction is 0.
- FSM:
  - DUAL, resolve & taken → REFILL_N, counter=RECOVER_CYC.
  - DUAL, resolve & ~taken → REFILL_T, counter=RECOVER_CYC.
  - REFILL_x, counter decrements each cycle; at 1 with no resolve → DUAL.
  - REFILL_x, resolve (valid path only) → redirect again. The next state follows the DUAL rules and the counter reloads.
  - Any state with dual_en=0 → SINGLE next cycle; a resolve in the same cycle is still applied first.
  - SINGLE with dual_en=1 → same cycle: correct_en_n=1, correction_n=ex_nextpc_t, flush_n all-ones; next state REFILL_N.
- path_valid (registered from state):
  - DUAL: 1/1.
  - REFILL_T: T=0, N=1.
  - REFILL_N: T=1, N=0.
  - SINGLE: T=1, N=0.
- Counters: resolve_cnt +1 per resolve cycle; taken_cnt +1 per resolve&taken. Both saturate at all-ones and never wrap.

Decomposition:
- Package eager_pkg holds the state encoding localparams (DUAL, REFILL_T, REFILL_N, SINGLE) and the default PC_W.
- One sub-module, sat_counter (CNT_W, inc), is instantiated twice.
- The lowest-set-slot select is an inline function.

Test Plan:
- Reset → state=0, path_valid=1/1, counters=0, all correct_en and flush=0.
- DUAL, ex_br_t=01, ex_taken_t=01, ex_nextpc_t=0x40, no ID branch → correct_en_n=1, correction_n=0x40, flush_n=11. Next cycle state=2, path_valid_n=0; after 2 cycles state=0.
- DUAL, ex_br_n=10, taken=0, id_br_n=10, id_bta_n slot1=0x7F, id_nextpc_t=0x12 ≠ id_nextpc_n=0x13 → correct_en_t=1, correction_t=0x7F, flush_t=11.
- REFILL_N, ex_br_n=01, taken=1 (invalid path) → no redirect. Same cycle with ex_br_t=01, ex_taken_t=0 instead → redirect T, state=1, counter reloads.
- dual_en 1→0 → SINGLE, path_valid_n=0, branches ignored. dual_en→1 with ex_nextpc_t=0x20 → correct_en_n=1, correction_n=0x20, then state REFILL_N.
- CNT_W=2, five taken resolutions → resolve_cnt=taken_cnt=3, held at 3.
